// File: rtl/ac_pkg.sv
// Shared air-conditioner control definitions: compressor FSM encodings and the
// PLL-derived control clock rate. The controller decodes state_o with these.
package ac_pkg;

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RUN_MIN = 2'd2,
        ST_RUN     = 2'd3
    } ac_state_e;

    localparam int AC_CLK_HZ = 100000;

endpackage

// File: rtl/sec_prescaler.sv
// Free-running divider producing a one-cycle pulse once per TICKS_PER_SEC clocks.
// The pulse is decoded from the count, so it is high while count == TICKS_PER_SEC-1.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = ac_pkg::AC_CLK_HZ
) (
    input  logic clk_ac_i,
    input  logic rst_n_i,
    output logic tick_o
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_ac_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/compressor_driver.sv
// Compressor/fan actuator driver enforcing minimum on-time, restart lockout and
// fan overrun after every stop, all timed in seconds from an on-chip prescaler.
module compressor_driver
    import ac_pkg::*;
#(
    parameter int TICKS_PER_SEC = AC_CLK_HZ,
    parameter int MIN_ON_S      = 600,
    parameter int MIN_OFF_S     = 900,
    parameter int FAN_OVERRUN_S = 30,
    parameter int CNT_W         = 10
) (
    input  logic             clk_ac_i,
    input  logic             rst_n_i,
    input  logic             req_on_i,
    input  logic             fault_i,
    output logic             comp_en_o,
    output logic             fan_en_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] remaining_s_o,
    output logic             sec_tick_o
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON_S);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF_S);
    localparam logic [CNT_W-1:0] OVR_LOAD = CNT_W'(FAN_OVERRUN_S);

    ac_state_e        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic             comp_q, comp_d;
    logic             fan_q, fan_d;
    logic             tick;
    logic             go_lock;

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk_ac_i(clk_ac_i),
        .rst_n_i (rst_n_i),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ovr_d   = ovr_q;
        go_lock = 1'b0;

        if (tick && (ovr_q != '0)) ovr_d = ovr_q - CNT_W'(1);

        case (state_q)
            ST_LOCKOUT: begin
                // A persisting fault keeps the lockout pinned at its full length.
                if (fault_i) begin
                    rem_d = OFF_LOAD;
                end else if (tick) begin
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                rem_d = '0;
                if (req_on_i && !fault_i) begin
                    state_d = ST_RUN_MIN;
                    rem_d   = ON_LOAD;
                end
            end
            ST_RUN_MIN: begin
                if (fault_i) begin
                    go_lock = 1'b1;
                end else if (tick) begin
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                rem_d = '0;
                if (fault_i || !req_on_i) go_lock = 1'b1;
            end
            default: begin
                state_d = ST_LOCKOUT;
                rem_d   = OFF_LOAD;
            end
        endcase

        // Stop loads win over any same-cycle tick decrement.
        if (go_lock) begin
            state_d = ST_LOCKOUT;
            rem_d   = OFF_LOAD;
            ovr_d   = OVR_LOAD;
        end

        comp_d = (state_d == ST_RUN_MIN) || (state_d == ST_RUN);
        fan_d  = comp_d || (ovr_d != '0);
    end

    always_ff @(posedge clk_ac_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_LOCKOUT;
            rem_q   <= OFF_LOAD;
            ovr_q   <= '0;
            comp_q  <= 1'b0;
            fan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ovr_q   <= ovr_d;
            comp_q  <= comp_d;
            fan_q   <= fan_d;
        end
    end

    assign comp_en_o     = comp_q;
    assign fan_en_o      = fan_q;
    assign state_o       = state_q;
    assign remaining_s_o = rem_q;
    assign sec_tick_o    = tick;

endmodule

// File: tb/tb_compressor_driver.sv
// Directed timeline bench for compressor_driver with a 4-cycle second,
// 3 s minimum on, 5 s lockout and 2 s fan overrun.
module tb_compressor_driver;

    localparam int CNT_W = 4;

    logic             clk_ac_i;
    logic             rst_n_i;
    logic             req_on_i;
    logic             fault_i;
    logic             comp_en_o;
    logic             fan_en_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] remaining_s_o;
    logic             sec_tick_o;

    int checks   = 0;
    int failures = 0;

    compressor_driver #(
        .TICKS_PER_SEC(4),
        .MIN_ON_S     (3),
        .MIN_OFF_S    (5),
        .FAN_OVERRUN_S(2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_ac_i     (clk_ac_i),
        .rst_n_i      (rst_n_i),
        .req_on_i     (req_on_i),
        .fault_i      (fault_i),
        .comp_en_o    (comp_en_o),
        .fan_en_o     (fan_en_o),
        .state_o      (state_o),
        .remaining_s_o(remaining_s_o),
        .sec_tick_o   (sec_tick_o)
    );

    initial clk_ac_i = 1'b0;
    always #5 clk_ac_i = ~clk_ac_i;

    // at: edge number (counted from reset release) after which outputs are checked;
    // req/fault are held on every edge up to and including it.
    typedef struct {
        int         at;
        logic       req;
        logic       fault;
        logic [1:0] st;
        logic [3:0] rem;
        logic       comp;
        logic       fan;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] rem,
                           input logic comp, input logic fan, input logic tick);
        chk({tag, ".state"}, int'(state_o), int'(st));
        chk({tag, ".remaining"}, int'(remaining_s_o), int'(rem));
        chk({tag, ".comp_en"}, int'(comp_en_o), int'(comp));
        chk({tag, ".fan_en"}, int'(fan_en_o), int'(fan));
        chk({tag, ".sec_tick"}, int'(sec_tick_o), int'(tick));
    endtask

    task automatic add(input int at, input logic req, input logic fault, input logic [1:0] st,
                       input logic [3:0] rem, input logic comp, input logic fan, input logic tick);
        vec_t v;
        v.at = at; v.req = req; v.fault = fault; v.st = st;
        v.rem = rem; v.comp = comp; v.fan = fan; v.tick = tick;
        vecs.push_back(v);
    endtask

    initial begin
        int cur;

        // power-up lockout with request held
        add(  3, 1, 0, 0, 5, 0, 0, 1);
        add(  4, 1, 0, 0, 4, 0, 0, 0);
        add(  8, 1, 0, 0, 3, 0, 0, 0);
        add( 19, 1, 0, 0, 1, 0, 0, 1);
        add( 20, 1, 0, 1, 0, 0, 0, 0);
        add( 21, 1, 0, 2, 3, 1, 1, 0);
        // request dropped during min-on is ignored, then RUN stops next cycle
        add( 24, 0, 0, 2, 2, 1, 1, 0);
        add( 31, 0, 0, 2, 1, 1, 1, 1);
        add( 32, 0, 0, 3, 0, 1, 1, 0);
        add( 33, 0, 0, 0, 5, 0, 1, 0);
        add( 39, 0, 0, 0, 4, 0, 1, 1);
        add( 40, 0, 0, 0, 3, 0, 0, 0);
        // fault freezes lockout at full length; request ignored in lockout
        add( 41, 1, 1, 0, 5, 0, 0, 0);
        add( 80, 0, 1, 0, 5, 0, 0, 0);
        add( 99, 0, 0, 0, 1, 0, 0, 1);
        add(100, 0, 0, 1, 0, 0, 0, 0);
        // one-cycle request pulse from IDLE
        add(101, 1, 0, 2, 3, 1, 1, 0);
        add(112, 0, 0, 3, 0, 1, 1, 0);
        add(113, 0, 0, 0, 5, 0, 1, 0);
        add(119, 0, 0, 0, 4, 0, 1, 1);
        add(120, 0, 0, 0, 3, 0, 0, 0);
        add(132, 0, 0, 1, 0, 0, 0, 0);
        // fault in RUN_MIN overrides minimum on-time
        add(133, 1, 0, 2, 3, 1, 1, 0);
        add(136, 0, 0, 2, 2, 1, 1, 0);
        add(137, 0, 1, 0, 5, 0, 1, 0);
        add(143, 0, 0, 0, 4, 0, 1, 1);
        add(144, 0, 0, 0, 3, 0, 0, 0);
        add(156, 0, 0, 1, 0, 0, 0, 0);
        // fault beats request in IDLE
        add(157, 1, 1, 1, 0, 0, 0, 0);
        add(158, 1, 0, 2, 3, 1, 1, 0);
        add(171, 1, 0, 3, 0, 1, 1, 1);
        // stop coincides with a tick: loads win, overrun not decremented
        add(172, 0, 0, 0, 5, 0, 1, 0);
        add(176, 0, 0, 0, 4, 0, 1, 0);
        add(180, 0, 0, 0, 3, 0, 0, 0);
        add(192, 0, 0, 1, 0, 0, 0, 0);
        add(205, 1, 0, 3, 0, 1, 1, 0);

        rst_n_i  = 1'b0;
        req_on_i = 1'b0;
        fault_i  = 1'b0;
        repeat (3) @(posedge clk_ac_i);
        @(negedge clk_ac_i);
        chk_all("reset", 2'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        rst_n_i = 1'b1;
        cur = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            req_on_i = vecs[i].req;
            fault_i  = vecs[i].fault;
            repeat (vecs[i].at - cur) @(posedge clk_ac_i);
            @(negedge clk_ac_i);
            cur = vecs[i].at;
            chk_all($sformatf("vec%0d@e%0d", i, vecs[i].at), vecs[i].st, vecs[i].rem,
                    vecs[i].comp, vecs[i].fan, vecs[i].tick);
        end

        // asynchronous reset between edges while running
        #2 rst_n_i = 1'b0;
        #1 chk_all("async_rst", 2'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk_ac_i);
        rst_n_i = 1'b1;
        repeat (3) @(posedge clk_ac_i);
        @(negedge clk_ac_i);
        chk_all("post_rst_e3", 2'd0, 4'd5, 1'b0, 1'b0, 1'b1);
        @(posedge clk_ac_i);
        @(negedge clk_ac_i);
        chk_all("post_rst_e4", 2'd0, 4'd4, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
